// File: rtl/prog_mod_counter_if.sv
// rtl/prog_mod_counter_if.sv - control/status bundle for the programmable modulo counter
interface prog_mod_counter_if #(
  parameter int WIDTH = 8
);
  logic             en;
  logic             clr;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic             up_dn;
  logic [WIDTH-1:0] mod_val;
  logic [1:0]       mode;
  logic [WIDTH-1:0] count;
  logic             tc;
  logic             wrap;
  logic             done;

  modport master (
    output en, clr, load, load_val, up_dn, mod_val, mode,
    input  count, tc, wrap, done
  );

  modport slave (
    input  en, clr, load, load_val, up_dn, mod_val, mode,
    output count, tc, wrap, done
  );
endinterface

// File: rtl/prog_mod_counter.sv
// rtl/prog_mod_counter.sv - runtime-programmable up/down modulo counter with wrap/saturate/one-shot modes
module prog_mod_counter #(
  parameter int              WIDTH   = 8,
  parameter longint unsigned DEF_MOD = 64'd1 << WIDTH
) (
  input  logic                clk,
  input  logic                rst,
  prog_mod_counter_if.slave   bus
);
  localparam logic [WIDTH:0]   DEF_M = DEF_MOD[WIDTH:0];
  localparam logic [WIDTH-1:0] ONE   = {{(WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic {RUN, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] count_q;
  logic             wrap_q;
  logic             done_q;

  logic [WIDTH:0]   m;
  logic [WIDTH-1:0] m_last;
  logic [WIDTH-1:0] term;
  logic [WIDTH-1:0] start;
  logic             oor;
  logic             wrap_mode;

  // M is carried one bit wider so DEF_MOD = 2**WIDTH is representable.
  assign m         = (bus.mod_val == '0) ? DEF_M : {1'b0, bus.mod_val};
  assign m_last    = WIDTH'(m - 1'b1);
  assign term      = bus.up_dn ? m_last : '0;
  assign start     = bus.up_dn ? '0 : m_last;
  assign oor       = ({1'b0, count_q} >= m);
  assign wrap_mode = (bus.mode == 2'b00) || (bus.mode == 2'b11);

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
      wrap_q  <= 1'b0;
      done_q  <= 1'b0;
      state   <= RUN;
    end else if (bus.clr) begin
      count_q <= start;
      wrap_q  <= 1'b0;
      done_q  <= 1'b0;
      state   <= RUN;
    end else if (bus.load) begin
      count_q <= (bus.load_val > m_last) ? m_last : bus.load_val;
      wrap_q  <= 1'b0;
      done_q  <= 1'b0;
      state   <= RUN;
    end else if (bus.en && state == RUN) begin
      wrap_q <= 1'b0;
      if (oor) begin
        // Shrunken modulus: up re-enters at 0 (or terminal when not wrapping), down at M-1.
        if (!bus.up_dn) begin
          count_q <= m_last;
        end else if (wrap_mode) begin
          count_q <= '0;
          wrap_q  <= 1'b1;
        end else begin
          count_q <= m_last;
          if (bus.mode == 2'b10) begin
            state  <= DONE;
            done_q <= 1'b1;
          end
        end
      end else if (count_q == term) begin
        if (wrap_mode) begin
          count_q <= start;
          wrap_q  <= 1'b1;
        end else if (bus.mode == 2'b10) begin
          state  <= DONE;
          done_q <= 1'b1;
        end
      end else begin
        count_q <= bus.up_dn ? count_q + ONE : count_q - ONE;
      end
    end else begin
      wrap_q <= 1'b0;
    end
  end

  assign bus.count = count_q;
  assign bus.tc    = !oor && (count_q == term);
  assign bus.wrap  = wrap_q;
  assign bus.done  = done_q;
endmodule

// File: tb/tb_prog_mod_counter.sv
// tb/tb_prog_mod_counter.sv - self-checking bench for prog_mod_counter against a behavioural model
module tb_prog_mod_counter;
  localparam int WIDTH   = 4;
  localparam int DEF_MOD = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  int m_count = 0;
  int m_wrap  = 0;
  int m_done  = 0;

  prog_mod_counter_if #(.WIDTH(WIDTH)) bus ();

  prog_mod_counter #(.WIDTH(WIDTH), .DEF_MOD(DEF_MOD)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  function automatic int eff_mod();
    return (bus.mod_val == 0) ? DEF_MOD : int'(bus.mod_val);
  endfunction

  function automatic int model_tc();
    int mm = eff_mod();
    if (m_count > mm - 1) return 0;
    return (m_count == (bus.up_dn ? mm - 1 : 0)) ? 1 : 0;
  endfunction

  // Reference behaviour: modular arithmetic on the effective modulus.
  task automatic model_step();
    int mm;
    int last;
    int md;
    mm   = eff_mod();
    last = mm - 1;
    md   = int'(bus.mode);
    if (rst) begin
      m_count = 0; m_wrap = 0; m_done = 0;
    end else if (bus.clr) begin
      m_count = bus.up_dn ? 0 : last; m_wrap = 0; m_done = 0;
    end else if (bus.load) begin
      m_count = (int'(bus.load_val) < last) ? int'(bus.load_val) : last;
      m_wrap = 0; m_done = 0;
    end else if (bus.en && !m_done) begin
      m_wrap = 0;
      if (m_count > last) begin
        if (!bus.up_dn) m_count = last;
        else if (md == 1 || md == 2) begin
          m_count = last;
          if (md == 2) m_done = 1;
        end else begin
          m_count = 0; m_wrap = 1;
        end
      end else if (md == 1 || md == 2) begin
        if (m_count == (bus.up_dn ? last : 0)) begin
          if (md == 2) m_done = 1;
        end else m_count = bus.up_dn ? m_count + 1 : m_count - 1;
      end else begin
        m_wrap  = bus.up_dn ? (m_count == last) : (m_count == 0);
        m_count = bus.up_dn ? (m_count + 1) % mm : (m_count + mm - 1) % mm;
      end
    end else begin
      m_wrap = 0;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic drive(input logic e, input logic c, input logic l, input int lv,
                       input logic ud, input int mv, input int md);
    bus.en = e; bus.clr = c; bus.load = l; bus.load_val = 4'(lv);
    bus.up_dn = ud; bus.mod_val = 4'(mv); bus.mode = 2'(md);
  endtask

  task automatic test_reset();
    drive(0, 0, 0, 0, 1, 10, 0);
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    #1;
    checks++;
    if (bus.count !== 4'd0 || bus.wrap !== 1'b0 || bus.done !== 1'b0) begin
      errors++;
      $display("FAIL reset count=%0d wrap=%0b done=%0b expected 0/0/0", bus.count, bus.wrap, bus.done);
    end
    checks++;
    if (bus.tc !== 1'b0) begin
      errors++;
      $display("FAIL reset_tc got %0b expected 0", bus.tc);
    end
  endtask

  task automatic test_wrap_up();
    int pulses = 0;
    drive(0, 1, 0, 0, 1, 10, 0);
    tick();
    bus.clr = 1'b0; bus.en = 1'b1;
    for (int k = 1; k <= 25; k++) begin
      checks++;
      if (bus.tc !== ((k - 1) % 10 == 9)) begin
        errors++;
        $display("FAIL wrap_up_tc step %0d got %0b", k, bus.tc);
      end
      tick();
      if (bus.wrap === 1'b1) pulses++;
      checks++;
      if (bus.count !== 4'(k % 10) || bus.wrap !== (k % 10 == 0)) begin
        errors++;
        $display("FAIL wrap_up step %0d count=%0d wrap=%0b expected %0d/%0b",
                 k, bus.count, bus.wrap, k % 10, (k % 10 == 0));
      end
    end
    checks++;
    if (pulses != 2) begin
      errors++;
      $display("FAIL wrap_up_pulses got %0d expected 2", pulses);
    end
  endtask

  task automatic test_down();
    drive(0, 1, 0, 0, 0, 6, 0);
    tick();
    checks++;
    if (bus.count !== 4'd5) begin
      errors++;
      $display("FAIL down_clr count=%0d expected 5", bus.count);
    end
    bus.clr = 1'b0; bus.en = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      tick();
      checks++;
      if (bus.count !== 4'((5 - k + 12) % 6) || bus.wrap !== (k == 6) ||
          bus.tc !== (((5 - k + 12) % 6) == 0)) begin
        errors++;
        $display("FAIL down step %0d count=%0d wrap=%0b tc=%0b expected count %0d",
                 k, bus.count, bus.wrap, bus.tc, (5 - k + 12) % 6);
      end
    end
  endtask

  task automatic test_saturate();
    drive(0, 1, 0, 0, 1, 5, 1);
    tick();
    bus.clr = 1'b0; bus.en = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      tick();
      checks++;
      if (bus.count !== 4'((k < 4) ? k : 4) || bus.wrap !== 1'b0 || bus.tc !== (k >= 4)) begin
        errors++;
        $display("FAIL saturate step %0d count=%0d wrap=%0b tc=%0b", k, bus.count, bus.wrap, bus.tc);
      end
    end
  endtask

  task automatic test_oneshot();
    int exp_c [4] = '{1, 2, 2, 2};
    int exp_d [4] = '{0, 0, 1, 1};
    drive(0, 1, 0, 0, 1, 3, 2);
    tick();
    bus.clr = 1'b0; bus.en = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      checks++;
      if (bus.count !== 4'(exp_c[k]) || bus.done !== 1'(exp_d[k]) || bus.wrap !== 1'b0) begin
        errors++;
        $display("FAIL oneshot step %0d count=%0d done=%0b expected %0d/%0d",
                 k, bus.count, bus.done, exp_c[k], exp_d[k]);
      end
    end
    bus.load = 1'b1; bus.load_val = 4'd1;
    tick();
    bus.load = 1'b0;
    checks++;
    if (bus.count !== 4'd1 || bus.done !== 1'b0) begin
      errors++;
      $display("FAIL oneshot_load count=%0d done=%0b expected 1/0", bus.count, bus.done);
    end
    tick();
    checks++;
    if (bus.count !== 4'd2) begin
      errors++;
      $display("FAIL oneshot_resume count=%0d expected 2", bus.count);
    end
  endtask

  task automatic test_priority();
    drive(1, 1, 1, 3, 1, 8, 0);
    tick();
    checks++;
    if (bus.count !== 4'd0) begin
      errors++;
      $display("FAIL prio_clr_up count=%0d expected 0", bus.count);
    end
    bus.up_dn = 1'b0;
    tick();
    checks++;
    if (bus.count !== 4'd7) begin
      errors++;
      $display("FAIL prio_clr_down count=%0d expected 7", bus.count);
    end
    drive(1, 0, 1, 12, 1, 8, 0);
    tick();
    checks++;
    if (bus.count !== 4'd7) begin
      errors++;
      $display("FAIL load_clamp count=%0d expected 7", bus.count);
    end
    drive(1, 0, 0, 0, 1, 8, 0);
    tick();
    checks++;
    if (bus.wrap !== 1'b1 || bus.count !== 4'd0) begin
      errors++;
      $display("FAIL prio_prewrap count=%0d wrap=%0b expected 0/1", bus.count, bus.wrap);
    end
    drive(1, 1, 1, 5, 1, 8, 2);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (bus.count !== 4'd0 || bus.wrap !== 1'b0 || bus.done !== 1'b0) begin
      errors++;
      $display("FAIL prio_rst count=%0d wrap=%0b done=%0b expected 0/0/0", bus.count, bus.wrap, bus.done);
    end
  endtask

  task automatic test_mod_change();
    drive(0, 0, 1, 9, 1, 0, 0);
    tick();
    bus.load = 1'b0; bus.mod_val = 4'd4;
    #1;
    checks++;
    if (bus.count !== 4'd9 || bus.tc !== 1'b0) begin
      errors++;
      $display("FAIL oor_tc count=%0d tc=%0b expected 9/0", bus.count, bus.tc);
    end
    bus.en = 1'b1;
    tick();
    checks++;
    if (bus.count !== 4'd0 || bus.wrap !== 1'b1) begin
      errors++;
      $display("FAIL oor_up count=%0d wrap=%0b expected 0/1", bus.count, bus.wrap);
    end
    drive(0, 0, 1, 15, 1, 0, 0);
    tick();
    checks++;
    if (bus.count !== 4'd15 || bus.tc !== 1'b1) begin
      errors++;
      $display("FAIL defmod_tc count=%0d tc=%0b expected 15/1", bus.count, bus.tc);
    end
    drive(1, 0, 0, 0, 1, 0, 0);
    tick();
    checks++;
    if (bus.count !== 4'd0 || bus.wrap !== 1'b1) begin
      errors++;
      $display("FAIL defmod_wrap count=%0d wrap=%0b expected 0/1", bus.count, bus.wrap);
    end
  endtask

  task automatic test_mod_one();
    drive(1, 1, 0, 0, 1, 1, 0);
    tick();
    bus.clr = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++;
      if (bus.count !== 4'd0 || bus.tc !== 1'b1 || bus.wrap !== 1'b1) begin
        errors++;
        $display("FAIL mod_one step %0d count=%0d tc=%0b wrap=%0b expected 0/1/1",
                 k, bus.count, bus.tc, bus.wrap);
      end
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 600; k++) begin
      drive(($urandom_range(0, 9) < 8), ($urandom_range(0, 39) == 0), ($urandom_range(0, 24) == 0),
            int'($urandom_range(0, 15)), ($urandom_range(0, 9) < 7),
            (($urandom_range(0, 19) == 0) ? int'($urandom_range(0, 15)) : int'(bus.mod_val)),
            (($urandom_range(0, 29) == 0) ? int'($urandom_range(0, 3)) : int'(bus.mode)));
      rst = ($urandom_range(0, 99) == 0);
      #1;
      checks++;
      if (bus.tc !== 1'(model_tc())) begin
        errors++;
        $display("FAIL rand_tc iter %0d got %0b expected %0d", k, bus.tc, model_tc());
      end
      tick();
      checks++;
      if (bus.count !== 4'(m_count) || bus.wrap !== 1'(m_wrap) || bus.done !== 1'(m_done)) begin
        errors++;
        $display("FAIL rand iter %0d count=%0d wrap=%0b done=%0b expected %0d/%0d/%0d",
                 k, bus.count, bus.wrap, bus.done, m_count, m_wrap, m_done);
      end
    end
    rst = 1'b0;
  endtask

  initial begin
    drive(0, 0, 0, 0, 1, 10, 0);
    #2;
    test_reset();
    test_wrap_up();
    test_down();
    test_saturate();
    test_oneshot();
    test_priority();
    test_mod_change();
    test_mod_one();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
